// File: rtl/debug_cmd_master.sv
// Byte-stream command master for the CPU debug access port: parses READ/WRITE frames,
// issues one debug access per frame and streams status/read data back. Optional macro: DBG_CMD_AUTOINC_EN.
module debug_cmd_master #(
  parameter int TIMEOUT_CYCLES = 16,
  parameter int TO_W           = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cmd_valid,
  input  logic [7:0]  cmd_data,
  output logic        cmd_ready,
  output logic        rsp_valid,
  output logic [7:0]  rsp_data,
  input  logic        rsp_ready,
  output logic        dbg_enable,
  output logic [11:0] dbg_addr,
  output logic        dbg_read,
  output logic        dbg_write,
  output logic [31:0] dbg_write_data,
  input  logic [31:0] dbg_read_data,
  input  logic        dbg_ready,
  output logic        busy
);

  typedef enum logic [2:0] {
    S_IDLE, S_ADDR_HI, S_ADDR_LO, S_WDATA, S_ISSUE, S_WAIT, S_RSP_STATUS, S_RSP_DATA
  } state_t;

  localparam logic [7:0] OP_READ       = 8'h01;
  localparam logic [7:0] OP_WRITE      = 8'h02;
  localparam logic [7:0] ST_OK         = 8'h00;
  localparam logic [7:0] ST_TIMEOUT    = 8'hEE;
  localparam logic [7:0] ST_ILLEGAL    = 8'hFF;
  // Expire when the incremented count reaches TIMEOUT_CYCLES-1, so the status byte
  // appears TIMEOUT_CYCLES cycles after the strobe.
  localparam logic [TO_W-1:0] TO_LAST  = TO_W'(TIMEOUT_CYCLES - 2);

  state_t           state_q, state_d;
  logic             is_write_q, is_write_d;
  logic [11:0]      addr_q, addr_d;
  logic [31:0]      wdata_q, wdata_d;
  logic [31:0]      rdata_q, rdata_d;
  logic [7:0]       status_q, status_d;
  logic [1:0]       cnt_q, cnt_d;
  logic [TO_W-1:0]  to_q, to_d;
  logic             cmd_ready_q, cmd_ready_d;
  logic             cmd_fire, rsp_fire;
`ifdef DBG_CMD_AUTOINC_EN
  localparam logic [7:0] OP_READ_NEXT  = 8'h03;
  localparam logic [7:0] OP_WRITE_NEXT = 8'h04;
  logic [11:0]      next_addr_q, next_addr_d;
`endif

  assign cmd_fire = cmd_valid && cmd_ready_q;
  assign rsp_fire = rsp_valid && rsp_ready;

  always_comb begin
    state_d     = state_q;
    is_write_d  = is_write_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    rdata_d     = rdata_q;
    status_d    = status_q;
    cnt_d       = cnt_q;
    to_d        = to_q;
`ifdef DBG_CMD_AUTOINC_EN
    next_addr_d = next_addr_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (cmd_fire) begin
          case (cmd_data)
            OP_READ: begin
              is_write_d = 1'b0;
              state_d    = S_ADDR_HI;
            end
            OP_WRITE: begin
              is_write_d = 1'b1;
              state_d    = S_ADDR_HI;
            end
`ifdef DBG_CMD_AUTOINC_EN
            OP_READ_NEXT: begin
              is_write_d = 1'b0;
              addr_d     = next_addr_q;
              state_d    = S_ISSUE;
            end
            OP_WRITE_NEXT: begin
              is_write_d = 1'b1;
              addr_d     = next_addr_q;
              cnt_d      = 2'd0;
              state_d    = S_WDATA;
            end
`endif
            default: begin
              status_d = ST_ILLEGAL;
              state_d  = S_RSP_STATUS;
            end
          endcase
        end
      end
      S_ADDR_HI: begin
        if (cmd_fire) begin
          addr_d[11:8] = cmd_data[3:0];
          state_d      = S_ADDR_LO;
        end
      end
      S_ADDR_LO: begin
        if (cmd_fire) begin
          addr_d[7:0] = cmd_data;
          cnt_d       = 2'd0;
          state_d     = is_write_q ? S_WDATA : S_ISSUE;
        end
      end
      S_WDATA: begin
        if (cmd_fire) begin
          wdata_d = {wdata_q[23:0], cmd_data};
          cnt_d   = cnt_q + 2'd1;
          if (cnt_q == 2'd3) state_d = S_ISSUE;
        end
      end
      S_ISSUE: begin
        to_d    = '0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        // A ready on the expiry cycle still wins over the timeout.
        if (dbg_ready) begin
          status_d = ST_OK;
          if (!is_write_q) rdata_d = dbg_read_data;
`ifdef DBG_CMD_AUTOINC_EN
          next_addr_d = addr_q + 12'd1;
`endif
          state_d  = S_RSP_STATUS;
        end else if (to_q == TO_LAST) begin
          status_d = ST_TIMEOUT;
          state_d  = S_RSP_STATUS;
        end else begin
          to_d = to_q + TO_W'(1);
        end
      end
      S_RSP_STATUS: begin
        if (rsp_fire) begin
          cnt_d   = 2'd0;
          state_d = (!is_write_q && status_q == ST_OK) ? S_RSP_DATA : S_IDLE;
        end
      end
      S_RSP_DATA: begin
        if (rsp_fire) begin
          cnt_d = cnt_q + 2'd1;
          if (cnt_q == 2'd3) state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
    cmd_ready_d = (state_d == S_IDLE) || (state_d == S_ADDR_HI) ||
                  (state_d == S_ADDR_LO) || (state_d == S_WDATA);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      is_write_q  <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      rdata_q     <= '0;
      status_q    <= '0;
      cnt_q       <= '0;
      to_q        <= '0;
      cmd_ready_q <= 1'b0;
`ifdef DBG_CMD_AUTOINC_EN
      next_addr_q <= '0;
`endif
    end else begin
      state_q     <= state_d;
      is_write_q  <= is_write_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      rdata_q     <= rdata_d;
      status_q    <= status_d;
      cnt_q       <= cnt_d;
      to_q        <= to_d;
      cmd_ready_q <= cmd_ready_d;
`ifdef DBG_CMD_AUTOINC_EN
      next_addr_q <= next_addr_d;
`endif
    end
  end

  always_comb begin
    rsp_data = 8'h00;
    if (state_q == S_RSP_STATUS) begin
      rsp_data = status_q;
    end else if (state_q == S_RSP_DATA) begin
      case (cnt_q)
        2'd0:    rsp_data = rdata_q[31:24];
        2'd1:    rsp_data = rdata_q[23:16];
        2'd2:    rsp_data = rdata_q[15:8];
        default: rsp_data = rdata_q[7:0];
      endcase
    end
  end

  assign cmd_ready      = cmd_ready_q;
  assign rsp_valid      = (state_q == S_RSP_STATUS) || (state_q == S_RSP_DATA);
  assign dbg_enable     = (state_q == S_ISSUE);
  assign dbg_read       = (state_q == S_ISSUE) && !is_write_q;
  assign dbg_write      = (state_q == S_ISSUE) && is_write_q;
  assign dbg_addr       = addr_q;
  assign dbg_write_data = wdata_q;
  assign busy           = (state_q != S_IDLE);

endmodule

// File: tb/tb_debug_cmd_master.sv
// Directed self-checking bench for debug_cmd_master with a one-cycle-latency debug port model.
module tb_debug_cmd_master;
  localparam int TO = 16;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        cmd_valid = 1'b0;
  logic [7:0]  cmd_data = 8'h00;
  logic        cmd_ready;
  logic        rsp_valid;
  logic [7:0]  rsp_data;
  logic        rsp_ready = 1'b1;
  logic        dbg_enable;
  logic [11:0] dbg_addr;
  logic        dbg_read;
  logic        dbg_write;
  logic [31:0] dbg_write_data;
  logic [31:0] dbg_read_data;
  logic        dbg_ready;
  logic        busy;

  always #5 clk = ~clk;

  debug_cmd_master #(.TIMEOUT_CYCLES(TO), .TO_W(8)) dut (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_data(cmd_data), .cmd_ready(cmd_ready),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_ready(rsp_ready),
    .dbg_enable(dbg_enable), .dbg_addr(dbg_addr), .dbg_read(dbg_read), .dbg_write(dbg_write),
    .dbg_write_data(dbg_write_data), .dbg_read_data(dbg_read_data), .dbg_ready(dbg_ready),
    .busy(busy)
  );

  int vecs = 0;
  int miscompares = 0;

  // Port model: answers a strobe with ready + 0xDEADBEEF exactly one cycle later.
  bit          port_resp = 1'b1;
  bit          stray = 1'b0;
  logic        pend = 1'b0;
  logic        port_ready = 1'b0;
  logic [31:0] port_data = 32'h0;
  always @(negedge clk) begin
    port_ready = pend;
    port_data  = pend ? 32'hDEADBEEF : 32'h0;
    pend       = dbg_enable && port_resp;
  end
  assign dbg_ready     = port_ready | stray;
  assign dbg_read_data = port_data;

  // Monitors: cycle counter, strobe capture, response byte log.
  int          cyc = 0;
  int          strobe_cnt = 0;
  int          strobe_cyc = 0;
  int          rise_cyc = 0;
  logic        strobe_rd = 1'b0, strobe_wr = 1'b0;
  logic [11:0] strobe_addr = '0;
  logic [31:0] strobe_wdata = '0;
  logic        rsp_valid_prev = 1'b0;
  logic [7:0]  rq[$];
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (dbg_enable) begin
      strobe_cnt   <= strobe_cnt + 1;
      strobe_cyc   <= cyc;
      strobe_rd    <= dbg_read;
      strobe_wr    <= dbg_write;
      strobe_addr  <= dbg_addr;
      strobe_wdata <= dbg_write_data;
    end
    if (rsp_valid && rsp_ready) rq.push_back(rsp_data);
    if (rsp_valid && !rsp_valid_prev) rise_cyc <= cyc;
    rsp_valid_prev <= rsp_valid;
  end

  task automatic send_byte(input logic [7:0] b);
    int n = 0;
    cmd_valid = 1'b1;
    cmd_data  = b;
    while (cmd_ready !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    vecs++;
    if (n >= 100) begin
      miscompares++;
      $display("FAIL cmd_accept byte=%02h cmd_ready=%b required 1", b, cmd_ready);
    end
    @(negedge clk);
    cmd_valid = 1'b0;
    cmd_data  = 8'h00;
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    while (busy !== 1'b0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    vecs++;
    if (n >= 200) begin
      miscompares++;
      $display("FAIL %s_idle busy=%b required 0", tag, busy);
    end
  endtask

  task automatic test_reset;
    reset = 1'b1;
    repeat (2) @(negedge clk);
    vecs++;
    if ({cmd_ready, rsp_valid, dbg_enable, dbg_read, dbg_write, busy} !== 6'b0) begin
      miscompares++;
      $display("FAIL reset_ctrl got=%b required 000000",
               {cmd_ready, rsp_valid, dbg_enable, dbg_read, dbg_write, busy});
    end
    vecs++;
    if ({dbg_addr, dbg_write_data, rsp_data} !== 52'h0) begin
      miscompares++;
      $display("FAIL reset_data addr=%03h wdata=%08h rsp=%02h required 0", dbg_addr, dbg_write_data, rsp_data);
    end
    reset = 1'b0;
    repeat (2) @(negedge clk);
    vecs++;
    if (cmd_ready !== 1'b1 || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL post_reset cmd_ready=%b busy=%b required 1/0", cmd_ready, busy);
    end
    $display("reset: released");
  endtask

  task automatic test_read;
    logic [7:0] exp [5] = '{8'h00, 8'hDE, 8'hAD, 8'hBE, 8'hEF};
    logic [7:0] got;
    int sb = strobe_cnt;
    int qb = rq.size();
    send_byte(8'h01); send_byte(8'h00); send_byte(8'h05);
    wait_idle("read");
    vecs++;
    if (strobe_cnt - sb !== 1 || strobe_rd !== 1'b1 || strobe_wr !== 1'b0) begin
      miscompares++;
      $display("FAIL read_strobe count=%0d rd=%b wr=%b required 1/1/0", strobe_cnt - sb, strobe_rd, strobe_wr);
    end
    vecs++;
    if (strobe_addr !== 12'h005) begin
      miscompares++;
      $display("FAIL read_addr got=%03h required 005", strobe_addr);
    end
    vecs++;
    if (rise_cyc - strobe_cyc !== 2) begin
      miscompares++;
      $display("FAIL read_latency got=%0d required 2", rise_cyc - strobe_cyc);
    end
    vecs++;
    if (rq.size() - qb !== 5) begin
      miscompares++;
      $display("FAIL read_rsp_count got=%0d required 5", rq.size() - qb);
    end
    for (int i = 0; i < 5; i++) begin
      got = (qb + i < rq.size()) ? rq[qb + i] : 8'hxx;
      vecs++;
      if (got !== exp[i]) begin
        miscompares++;
        $display("FAIL read_rsp_byte%0d got=%02h required %02h", i, got, exp[i]);
      end
    end
    $display("read: addr=%03h %0d response bytes", strobe_addr, rq.size() - qb);
  endtask

  task automatic test_write;
    logic [7:0] got;
    int sb = strobe_cnt;
    int qb = rq.size();
    send_byte(8'h02); send_byte(8'h08); send_byte(8'h10);
    send_byte(8'h12); send_byte(8'h34); send_byte(8'h56); send_byte(8'h78);
    wait_idle("write");
    vecs++;
    if (strobe_cnt - sb !== 1 || strobe_wr !== 1'b1 || strobe_rd !== 1'b0) begin
      miscompares++;
      $display("FAIL write_strobe count=%0d wr=%b rd=%b required 1/1/0", strobe_cnt - sb, strobe_wr, strobe_rd);
    end
    vecs++;
    if (strobe_addr !== 12'h810 || strobe_wdata !== 32'h12345678) begin
      miscompares++;
      $display("FAIL write_addr_data got=%03h/%08h required 810/12345678", strobe_addr, strobe_wdata);
    end
    got = (qb < rq.size()) ? rq[qb] : 8'hxx;
    vecs++;
    if (rq.size() - qb !== 1 || got !== 8'h00) begin
      miscompares++;
      $display("FAIL write_rsp count=%0d byte=%02h required 1/00", rq.size() - qb, got);
    end
    $display("write: addr=%03h data=%08h status=%02h", strobe_addr, strobe_wdata, got);
  endtask

  task automatic test_timeout;
    logic [7:0] got;
    int qb = rq.size();
    port_resp = 1'b0;
    send_byte(8'h01); send_byte(8'h0A); send_byte(8'hBC);
    wait_idle("timeout");
    port_resp = 1'b1;
    vecs++;
    if (rise_cyc - strobe_cyc !== TO) begin
      miscompares++;
      $display("FAIL timeout_latency got=%0d required %0d", rise_cyc - strobe_cyc, TO);
    end
    got = (qb < rq.size()) ? rq[qb] : 8'hxx;
    vecs++;
    if (rq.size() - qb !== 1 || got !== 8'hEE) begin
      miscompares++;
      $display("FAIL timeout_rsp count=%0d byte=%02h required 1/EE", rq.size() - qb, got);
    end
    $display("timeout: addr=%03h status=%02h", strobe_addr, got);
  endtask

  task automatic test_illegal;
    logic [7:0] got;
    int sb = strobe_cnt;
    int qb = rq.size();
    send_byte(8'h7A);
    wait_idle("illegal");
    got = (qb < rq.size()) ? rq[qb] : 8'hxx;
    vecs++;
    if (rq.size() - qb !== 1 || got !== 8'hFF || strobe_cnt !== sb) begin
      miscompares++;
      $display("FAIL illegal_rsp count=%0d byte=%02h strobes=%0d required 1/FF/0", rq.size() - qb, got, strobe_cnt - sb);
    end
    $display("illegal: opcode=7A status=%02h", got);
    test_read();
`ifndef DBG_CMD_AUTOINC_EN
    qb = rq.size();
    sb = strobe_cnt;
    send_byte(8'h03);
    wait_idle("rdnext_off");
    send_byte(8'h04);
    wait_idle("wrnext_off");
    vecs++;
    if (rq.size() - qb !== 2 || rq[qb] !== 8'hFF || rq[qb + 1] !== 8'hFF || strobe_cnt !== sb) begin
      miscompares++;
      $display("FAIL next_ops_illegal count=%0d strobes=%0d required 2 FF bytes, 0 strobes", rq.size() - qb, strobe_cnt - sb);
    end
    $display("illegal: opcodes 03/04 rejected");
`endif
  endtask

  task automatic test_backpressure;
    logic [7:0] exp [5] = '{8'h00, 8'hCA, 8'hFE, 8'hBE, 8'hEF};
    int qb = rq.size();
    int n;
    exp[1] = 8'hDE; exp[2] = 8'hAD;
    rsp_ready = 1'b0;
    send_byte(8'h01); send_byte(8'h02); send_byte(8'h34);
    for (int i = 0; i < 5; i++) begin
      n = 0;
      while (rsp_valid !== 1'b1 && n < 100) begin
        @(negedge clk);
        n++;
      end
      if (i == 3) begin
        for (int k = 0; k < 10; k++) begin
          @(negedge clk);
          vecs++;
          if (rsp_valid !== 1'b1 || rsp_data !== 8'hBE) begin
            miscompares++;
            $display("FAIL stall_hold cyc%0d valid=%b data=%02h required 1/BE", k, rsp_valid, rsp_data);
          end
        end
      end
      vecs++;
      if (rsp_valid !== 1'b1 || rsp_data !== exp[i]) begin
        miscompares++;
        $display("FAIL bp_byte%0d valid=%b data=%02h required 1/%02h", i, rsp_valid, rsp_data, exp[i]);
      end
      rsp_ready = 1'b1;
      @(negedge clk);
      rsp_ready = 1'b0;
    end
    rsp_ready = 1'b1;
    wait_idle("bp");
    vecs++;
    if (rq.size() - qb !== 5 || strobe_addr !== 12'h234) begin
      miscompares++;
      $display("FAIL bp_total count=%0d addr=%03h required 5/234", rq.size() - qb, strobe_addr);
    end
    $display("backpressure: addr=%03h %0d bytes with 10-cycle stall", strobe_addr, rq.size() - qb);
  endtask

  task automatic test_reset_in_wait;
    port_resp = 1'b0;
    send_byte(8'h01); send_byte(8'h00); send_byte(8'h07);
    repeat (4) @(negedge clk);
    vecs++;
    if (busy !== 1'b1 || cmd_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL wait_state busy=%b cmd_ready=%b required 1/0", busy, cmd_ready);
    end
    #1 reset = 1'b1;
    #1;
    vecs++;
    if ({cmd_ready, rsp_valid, dbg_enable, dbg_read, dbg_write, busy} !== 6'b0 || dbg_addr !== 12'h0) begin
      miscompares++;
      $display("FAIL reset_in_wait ctrl=%b addr=%03h required 0", {cmd_ready, rsp_valid, dbg_enable, dbg_read, dbg_write, busy}, dbg_addr);
    end
    @(negedge clk);
    reset = 1'b0;
    port_resp = 1'b1;
    $display("reset_in_wait: frame discarded");
    test_read();
  endtask

  task automatic test_stray_ready;
    int qb = rq.size();
    stray = 1'b1;
    @(negedge clk);
    stray = 1'b0;
    repeat (3) @(negedge clk);
    vecs++;
    if (busy !== 1'b0 || rq.size() !== qb) begin
      miscompares++;
      $display("FAIL stray_ready busy=%b rsp=%0d required 0/0", busy, rq.size() - qb);
    end
    $display("stray_ready: ignored in idle");
  endtask

`ifdef DBG_CMD_AUTOINC_EN
  task automatic test_autoinc;
    int qb;
    send_byte(8'h01); send_byte(8'h0F); send_byte(8'hFF);
    wait_idle("ai_first");
    qb = rq.size();
    send_byte(8'h03);
    wait_idle("ai_next");
    vecs++;
    if (strobe_addr !== 12'h000 || strobe_rd !== 1'b1 || rq.size() - qb !== 5) begin
      miscompares++;
      $display("FAIL autoinc_wrap addr=%03h rd=%b bytes=%0d required 000/1/5", strobe_addr, strobe_rd, rq.size() - qb);
    end
    $display("autoinc: read_next addr=%03h", strobe_addr);
  endtask
`endif

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    @(negedge clk);
    test_reset();
    test_read();
    test_write();
    test_timeout();
    test_illegal();
    test_backpressure();
    test_reset_in_wait();
    test_stray_ready();
`ifdef DBG_CMD_AUTOINC_EN
    test_autoinc();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vecs, miscompares);
    $finish;
  end

endmodule

// File: doc/debug_cmd_master.md
Name: debug_cmd_master

Overview:
- Host-side initiator for the CPU debug access port. Sits between a byte-stream link (UART/JTAG bridge) and the debug port's enable/addr/read/write/ready interface.
- Parses command frames from the byte link and issues exactly one debug read or write per frame.
- Waits for the port's ready pulse, then streams a status byte and any read data back over the byte link.

Parameters:
- TIMEOUT_CYCLES, 16, cycles to wait for dbg_ready after issue before declaring timeout (min 2).
- TO_W, 8, width of timeout counter (must hold TIMEOUT_CYCLES).

Ports:
- clk  in  1  clock
- reset  in  1  reset
- cmd_valid  in  1  command byte valid
- cmd_data  in  8  command byte
- cmd_ready  out  1  master accepts command byte
- rsp_valid  out  1  response byte valid
- rsp_data  out  8  response byte
- rsp_ready  in  1  link accepts response byte
- dbg_enable  out  1  debug port enable
- dbg_addr  out  12  debug address; [11]=0 GPR (addr[4:0]), [11]=1 CSR
- dbg_read  out  1  read strobe
- dbg_write  out  1  write strobe
- dbg_write_data  out  32  write data
- dbg_read_data  in  32  read data from port
- dbg_ready  in  1  one-cycle completion pulse from port
- busy  out  1  high whenever state != IDLE

Behaviour:
- Clock clk; reset is asynchronous, active-high. All outputs and registers reset to 0; state = IDLE.
- Byte transfers occur on valid&&ready, both directions. Multi-byte fields are MSB first.
- Frame format:
  - Byte 0: opcode. 0x01 = READ, 0x02 = WRITE.
  - Byte 1: addr_hi, of which bits[3:0] = addr[11:8] and bits[7:4] are ignored.
  - Byte 2: addr_lo.
  - WRITE only: 4 data bytes follow.
- States and transitions:
  - IDLE: cmd_ready=1. Legal opcode -> ADDR_HI. Illegal opcode -> latch status 0xFF -> RSP_STATUS; no address bytes are consumed.
  - ADDR_HI -> ADDR_LO: cmd_ready=1.
  - ADDR_LO: cmd_ready=1. -> WDATA if WRITE, else -> ISSUE.
  - WDATA: cmd_ready=1. Shift in 4 bytes (2-bit counter), then -> ISSUE.
  - ISSUE: exactly one cycle with dbg_enable=1, dbg_read or dbg_write=1, dbg_addr and dbg_write_data stable. Timeout counter cleared. -> WAIT.
  - WAIT: strobes are 0; dbg_addr and dbg_write_data hold.
    - dbg_ready=1: status 0x00; on READ, capture dbg_read_data the same cycle. -> RSP_STATUS.
    - Counter reaches TIMEOUT_CYCLES-1 with no ready: status 0xEE. -> RSP_STATUS.
  - RSP_STATUS: rsp_valid=1, rsp_data=status. On handshake: -> RSP_DATA if READ with status 0x00, else -> IDLE.
  - RSP_DATA: 4 bytes from the captured word, MSB first; rsp_data stable while rsp_valid && !rsp_ready. -> IDLE after the 4th handshake.
- cmd_ready=0 in ISSUE, WAIT, RSP_*. Command bytes are never dropped; the link stalls instead.
- A dbg_ready pulse outside WAIT is ignored.
- A dbg_ready pulse in the same cycle the timeout expires counts as success.
- Issue-to-earliest-status latency: ISSUE cycle, 1 WAIT cycle (port ready arrives 1 cycle after strobe), then status valid the next cycle.
- Reset mid-frame: discard partial frame and any pending response; all strobes deassert immediately.

Optional Feature:
- Macro: DBG_CMD_AUTOINC_EN.
- Defined:
  - Opcodes 0x03 (READ_NEXT) and 0x04 (WRITE_NEXT) are legal.
  - They skip the address bytes and use an internal 12-bit address register.
  - Every successful (status 0x00) access of any opcode sets that register to its access address + 1, wrapping 0xFFF -> 0x000.
  - The register resets to 0 and is unchanged on timeout.
- Undefined: 0x03/0x04 are illegal (status 0xFF); no address register is implemented.

Test Plan:
- Frame 01 00 05, port returns ready+0xDEADBEEF one cycle after strobe -> one-cycle dbg_read with dbg_addr=0x005; response bytes 00 DE AD BE EF.
- Frame 02 08 10 12 34 56 78 -> one-cycle dbg_write, dbg_addr=0x810, dbg_write_data=0x12345678; response 00 only.
- READ with dbg_ready never asserted (TIMEOUT_CYCLES=16) -> response EE exactly 16 cycles after strobe; no data bytes; busy drops after handshake.
- Opcode 0x7A -> immediate response FF, next byte 0x01 is parsed as a new opcode.
- Hold rsp_ready=0 for 10 cycles mid-RSP_DATA -> rsp_data/rsp_valid stable, no byte lost; assert reset in WAIT -> all outputs 0, next frame works.
- (DBG_CMD_AUTOINC_EN) 01 0F FF then 03 -> second read issues dbg_addr=0x000 (wrap).
